// File: rtl/ret_addr_stack_pkg.sv
// Shared constants and operation decode for the return-address stack.
// The CPU-wide address width and default stack depth live here.
package ret_addr_stack_pkg;

    localparam int RAS_ADDR_W = 19;
    localparam int RAS_DEPTH  = 16;

    typedef enum logic [1:0] {
        OP_NONE    = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } ras_op_e;

    // CALL+RET in one cycle rewrites the top in place, unless the stack is
    // empty, in which case it degrades to a plain push.
    function automatic ras_op_e ras_decode(input logic do_push,
                                           input logic do_pop,
                                           input logic is_empty);
        ras_op_e op;
        op = OP_NONE;
        if (do_push && do_pop && !is_empty) begin
            op = OP_REPLACE;
        end else if (do_push) begin
            op = OP_PUSH;
        end else if (do_pop) begin
            op = OP_POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/ret_addr_stack_mem.sv
// Entry storage: DEPTH x ADDR_W registers, one synchronous write port and
// one asynchronous read port. Contents are intentionally not reset.
module ras_mem
    import ret_addr_stack_pkg::*;
#(
    parameter int ADDR_W = RAS_ADDR_W,
    parameter int DEPTH  = RAS_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [ADDR_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [ADDR_W-1:0] rdata_o
);

    logic [ADDR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ret_addr_stack.sv
// Circular LIFO of CALL return addresses with a combinational top-of-stack
// read for zero-latency RET redirect, occupancy, and sticky error flags.
module ret_addr_stack
    import ret_addr_stack_pkg::*;
#(
    parameter int ADDR_W = RAS_ADDR_W,
    parameter int DEPTH  = RAS_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              stall,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] top_addr,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    logic [PTR_W-1:0]  sp_q, sp_d;
    logic [PTR_W-1:0]  sp_m1;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              do_push, do_pop;
    logic              is_empty, is_full;
    ras_op_e           op;

    logic              we;
    logic [PTR_W-1:0]  waddr;
    logic              ovf_evt, unf_evt;
    logic [ADDR_W-1:0] rdata;

    assign do_push  = push & ~stall;
    assign do_pop   = pop & ~stall;
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign sp_m1    = sp_q - PTR_W'(1);
    assign op       = ras_decode(do_push, do_pop, is_empty);

    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        we      = 1'b0;
        waddr   = sp_q;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        unique case (op)
            OP_PUSH: begin
                we    = 1'b1;
                waddr = sp_q;
                sp_d  = sp_q + PTR_W'(1);
                // When full the write lands on the oldest slot, dropping it.
                if (is_full) begin
                    ovf_evt = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
                // Only reachable with a pop when the stack was empty.
                unf_evt = do_pop;
            end
            OP_POP: begin
                if (is_empty) begin
                    unf_evt = 1'b1;
                end else begin
                    sp_d    = sp_m1;
                    count_d = count_q - CNT_W'(1);
                end
            end
            OP_REPLACE: begin
                we    = 1'b1;
                waddr = sp_m1;
            end
            default: begin
            end
        endcase
    end

    // A new error event wins over a simultaneous clear.
    assign ovf_d = (ovf_q & ~clr_err) | ovf_evt;
    assign unf_d = (unf_q & ~clr_err) | unf_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    ras_mem #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (push_addr),
        .raddr_i (sp_m1),
        .rdata_o (rdata)
    );

    assign top_addr  = is_empty ? '0 : rdata;
    assign empty     = is_empty;
    assign full      = is_full;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Bench for ret_addr_stack: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and randomized traffic.
module tb_ret_addr_stack;

    localparam int ADDR_W = 19;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              push, pop, stall, clr_err;
    logic [ADDR_W-1:0] push_addr;
    logic [ADDR_W-1:0] top_addr;
    logic              empty, full, overflow, underflow;
    logic [CNT_W-1:0]  count;

    ret_addr_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .stall     (stall),
        .push_addr (push_addr),
        .clr_err   (clr_err),
        .top_addr  (top_addr),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model: the stack is a queue, newest entry at the back.
    logic [ADDR_W-1:0] mq[$];
    bit m_ovf, m_unf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ADDR_W-1:0] m_top();
        return (mq.size() == 0) ? '0 : mq[mq.size()-1];
    endfunction

    task automatic model_step(input bit ps, input bit pp, input bit st, input bit cl,
                              input logic [ADDR_W-1:0] a);
        bit dp, dq, o, u;
        dp = ps && !st;
        dq = pp && !st;
        o = 1'b0;
        u = 1'b0;
        if (dp && dq && mq.size() > 0) begin
            mq[mq.size()-1] = a;
        end else if (dp) begin
            if (dq) u = 1'b1;
            if (mq.size() == DEPTH) begin
                void'(mq.pop_front());
                o = 1'b1;
            end
            mq.push_back(a);
        end else if (dq) begin
            if (mq.size() == 0) u = 1'b1;
            else void'(mq.pop_back());
        end
        if (cl) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        m_ovf = m_ovf | o;
        m_unf = m_unf | u;
    endtask

    task automatic cycle(input bit ps, input bit pp, input bit st, input bit cl,
                         input logic [ADDR_W-1:0] a);
        push = ps; pop = pp; stall = st; clr_err = cl; push_addr = a;
        @(posedge clk);
        if (!rst) model_step(ps, pp, st, cl, a);
        #1;
        push = 1'b0; pop = 1'b0; stall = 1'b0; clr_err = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("top_addr",  32'(top_addr),  32'(m_top()));
            check("count",     32'(count),     32'(mq.size()));
            check("empty",     32'(empty),     32'(mq.size() == 0));
            check("full",      32'(full),      32'(mq.size() == DEPTH));
            check("overflow",  32'(overflow),  32'(m_ovf));
            check("underflow", 32'(underflow), 32'(m_unf));
        end
    end

    task automatic do_reset();
        #2;
        rst = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_top",   32'(top_addr), 32'd0);
        check("rst_flags", 32'({overflow, underflow, full}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        push = 1'b0; pop = 1'b0; stall = 1'b0; clr_err = 1'b0; push_addr = '0;
        #1;
        check("por_empty", 32'(empty), 32'd1);
        check("por_top",   32'(top_addr), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Basic LIFO
        cycle(1, 0, 0, 0, 19'h00010);
        cycle(1, 0, 0, 0, 19'h00020);
        cycle(1, 0, 0, 0, 19'h00030);
        check("lifo_top",   32'(top_addr), 32'h30);
        check("lifo_count", 32'(count), 32'd3);
        check("lifo_pop0", 32'(top_addr), 32'h30); cycle(0, 1, 0, 0, '0);
        check("lifo_pop1", 32'(top_addr), 32'h20); cycle(0, 1, 0, 0, '0);
        check("lifo_pop2", 32'(top_addr), 32'h10); cycle(0, 1, 0, 0, '0);
        check("lifo_empty", 32'(empty), 32'd1);

        // Underflow and clear
        cycle(0, 1, 0, 0, '0);
        check("unf_set",   32'(underflow), 32'd1);
        check("unf_count", 32'(count), 32'd0);
        cycle(0, 0, 0, 1, '0);
        check("unf_clr", 32'(underflow), 32'd0);
        cycle(0, 1, 0, 1, '0);
        check("unf_prio", 32'(underflow), 32'd1);
        cycle(0, 0, 0, 1, '0);

        // Simultaneous push and pop
        cycle(1, 0, 0, 0, 19'h0000A);
        cycle(1, 0, 0, 0, 19'h0000B);
        cycle(1, 1, 0, 0, 19'h0000C);
        check("pp_top",   32'(top_addr), 32'h0C);
        check("pp_count", 32'(count), 32'd2);
        cycle(0, 1, 0, 0, '0);
        check("pp_after", 32'(top_addr), 32'h0A);
        cycle(0, 1, 0, 0, '0);

        // Overflow: 17 pushes, oldest lost
        for (int i = 0; i < 17; i++) cycle(1, 0, 0, 0, ADDR_W'(32'h100 + i));
        check("ovf_full",  32'(full), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_flag",  32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check("ovf_pop", 32'(top_addr), 32'h110 - 32'(i));
            cycle(0, 1, 0, 0, '0);
        end
        check("ovf_drain_empty", 32'(empty), 32'd1);
        cycle(0, 0, 0, 1, '0);

        // Randomized traffic, alternating push-heavy and pop-heavy phases
        for (int i = 0; i < 800; i++) begin
            int bias;
            bias = ((i / 100) % 2 == 0) ? 75 : 25;
            cycle($urandom_range(99) < bias, $urandom_range(99) < (100 - bias),
                  $urandom_range(9) == 0, $urandom_range(24) == 0, ADDR_W'($urandom));
        end

        // Asynchronous reset mid-run with a non-empty stack
        cycle(1, 0, 0, 0, 19'h12345);
        cycle(1, 0, 0, 0, 19'h23456);
        do_reset();

        // Stall blocks a held CALL; release acts exactly once
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 19'h7FFFF);
        check("stall_count", 32'(count), 32'd0);
        check("stall_top",   32'(top_addr), 32'd0);
        cycle(1, 0, 0, 0, 19'h7FFFF);
        check("stall_rel_count", 32'(count), 32'd1);
        check("stall_rel_top",   32'(top_addr), 32'h7FFFF);
        cycle(0, 1, 1, 0, '0);
        check("stall_pop_blocked", 32'(count), 32'd1);
        cycle(0, 0, 0, 0, '0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/ret_addr_stack.md
# ret_addr_stack

Hardware return-address stack for the 19-bit pipelined CPU, sitting directly downstream of the ID-stage control decoder. It consumes `ID_push` (CALL) and `ID_pop` (RET) and stores return addresses in a circular LIFO. It provides the top-of-stack address combinationally so the RET redirect resolves in the same cycle. It also reports occupancy and sticky overflow/underflow error flags.

## Interface
Parameters:
- `ADDR_W`, 19, width of instruction address / stack entry
- `DEPTH`, 16, number of entries; power of two, ≥ 2

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `push`  in  1  CALL in ID (`ID_push`); store `push_addr`
- `pop`  in  1  RET in ID (`ID_pop`); remove top entry
- `stall`  in  1  pipeline hold; when 1, `push` and `pop` are ignored
- `push_addr`  in  ADDR_W  return address (CALL PC + 1, computed upstream)
- `clr_err`  in  1  synchronous clear of the sticky error flags
- `top_addr`  out  ADDR_W  current top entry (the RET target); 0 when empty
- `empty`  out  1  count == 0
- `full`  out  1  count == DEPTH
- `count`  out  $clog2(DEPTH)+1  number of valid entries
- `overflow`  out  1  sticky; set on a push while full
- `underflow`  out  1  sticky; set on a pop while empty

## Operation
- State:
  - `sp` is $clog2(DEPTH) bits and points to the next free slot.
  - `count` saturates at DEPTH.
  - Storage is `DEPTH x ADDR_W`.
- Top entry is `mem[sp-1]`, with modulo-DEPTH wrap. `top_addr` is combinational from `mem`/`sp`; it is forced to 0 when `empty`.
- Effective events: `do_push = push & ~stall`, `do_pop = pop & ~stall`.
- Push only:
  - Write `mem[sp] <= push_addr`, then `sp <= sp+1`, which wraps DEPTH-1 → 0.
  - If not full: `count <= count+1`.
  - If full: the oldest entry is silently overwritten, `count` stays DEPTH, and `overflow <= 1`.
- Pop only:
  - If not empty: `sp <= sp-1` (wraps 0 → DEPTH-1) and `count <= count-1`.
  - If empty: no pointer or count change, and `underflow <= 1`.
- Push and pop together:
  - Not empty: replace the top in place with `mem[sp-1] <= push_addr`; `sp` and `count` are unchanged.
  - Empty: treat as push only, and set `underflow`.
- `clr_err` clears both sticky flags. If an error event occurs in the same cycle, the set takes priority.
- Memory contents are not reset. Only `sp`, `count` and the flags are reset.

## Timing
- Reset values, applied immediately and asynchronously:
  - `sp=0`, `count=0`, `empty=1`, `full=0`, `overflow=0`, `underflow=0`, `top_addr=0`.
- `top_addr` is valid in the same cycle RET is decoded, so a RET redirect has zero read latency.
- A push becomes visible on `top_addr` in the cycle after the edge. Back-to-back CALL followed by RET therefore returns the just-pushed address.
- A pop takes effect at the edge. In the next cycle `top_addr` shows the new top.
- `empty`, `full` and `count` are derived from registered state and update one edge after the event.
- The decoder already zeroes `push`/`pop` on hazard. `stall` additionally blocks repeated action while ID is held, so each CALL/RET acts exactly once.
- Reset asserted mid-sequence discards all entries. Operation resumes from empty on the first edge after `rst` falls.

## Structure
- Shared constants go in `parameter.v`, next to the opcode defines: `ADDR_W` (19) and `RAS_DEPTH` (16).
- A single sub-module, `ras_mem`, is natural. It is a DEPTH x ADDR_W register array with one synchronous write port and one asynchronous read port.
- Pointer, count and flag logic stay in `ret_addr_stack`.

## Test plan
- **Reset:** assert `rst` mid-run → `count=0`, `empty=1`, `top_addr=0`, flags 0, all asynchronously and before the next edge.
- **Basic LIFO:** push 0x00010, 0x00020, 0x00030 → `top_addr=0x00030`, `count=3`. Three pops return 0x00030, 0x00020, 0x00010, then `empty=1`.
- **Overflow:** push 17 values 0x100..0x110 with DEPTH=16 → `full=1`, `count=16`, `overflow=1`. Sixteen pops return 0x110 down to 0x101; 0x100 is lost.
- **Underflow and clear:**
  - Pop while empty → `underflow=1`; `sp` and `count` unchanged.
  - Then `clr_err` → `underflow=0`.
  - `clr_err` in the same cycle as an empty pop → `underflow=1`.
- **Simultaneous push and pop:** stack holds [0x0A, 0x0B]; push 0x0C with pop → `top_addr=0x0C`, `count=2`. A following pop exposes 0x0A.
- **Stall:** push 0x7FFFF with `stall=1` for 3 cycles → no change. Release `stall` with `push=1` for one cycle → exactly one entry, `top_addr=0x7FFFF`.
